// File: rtl/qdi_pkg.sv
// qdi_pkg: shared definitions for the clocked <-> QDI 1-of-4 bridges.
//   qdi_state_e    : handshake phase of the transmit FSM (NEUTRAL / VALID)
//   QDI_NEUTRAL    : all-rails-low spacer code
//   enc_1of4()     : 2-bit word -> one-hot rail pattern
//   is_valid_1of4(): true when exactly one rail is high
package qdi_pkg;

  typedef enum logic {
    NEUTRAL = 1'b0,
    VALID   = 1'b1
  } qdi_state_e;

  localparam logic [3:0] QDI_NEUTRAL = 4'b0000;

  function automatic logic [3:0] enc_1of4(input logic [1:0] v);
    enc_1of4 = 4'b0001 << v;
  endfunction

  // A power of two has exactly one bit set: r & (r-1) clears the lowest set bit.
  function automatic logic is_valid_1of4(input logic [3:0] r);
    is_valid_1of4 = (r != 4'b0000) && ((r & (r - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/sync2qdi_1of4_if.sv
// sync2qdi_1of4_if: host push port and QDI 1-of-4 transmit channel.
//   in_data/in_valid/in_ready : synchronous valid/ready push into the bridge
//   Tx                        : 1-of-4 data rails (0000 = neutral)
//   Txe                       : asynchronous enable/acknowledge from the consumer
// master: the bridge (accepts pushes, drives the rails)
// slave : the environment (host plus QDI consumer)
interface sync2qdi_1of4_if;
  logic [1:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] Tx;
  logic       Txe;

  modport master (
    input  in_data, in_valid, Txe,
    output in_ready, Tx
  );

  modport slave (
    output in_data, in_valid, Txe,
    input  in_ready, Tx
  );
endinterface

// File: rtl/sync2qdi_1of4_sync_ff.sv
// sync_ff: STAGES-deep reset-to-0 synchronizer for a single asynchronous bit.
//   clk : destination clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous input
//   q   : synchronized output (last stage)
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_p;

  always_ff @(posedge clk) begin
    if (rst) sync_p <= '0;
    else     sync_p <= {sync_p[STAGES-2:0], d};
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/sync2qdi_1of4.sv
// sync2qdi_1of4: buffers 2-bit host words in a small FIFO and issues each as a
// 1-of-4 token on a four-phase return-to-zero QDI channel.
//   CLK, RESET  : clock and synchronous active-high reset
//   bus         : sync2qdi_1of4_if.master (host push port + Tx/Txe channel)
//   busy        : FIFO non-empty or a token is on the rails
//   sent_count  : tokens acknowledged by the consumer (wraps)
// Parameters: DEPTH (FIFO entries, power of two >= 2), SYNC_STAGES (>= 2),
// CNT_W (sent_count width).
module sync2qdi_1of4
  import qdi_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  sync2qdi_1of4_if.master       bus,
  output logic                  busy,
  output logic [CNT_W-1:0]      sent_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] count;
  logic [OW-1:0] count_nxt;
  logic          in_ready_r;
  logic          push;
  logic          pop;

  logic          txe_s;
  qdi_state_e    state;
  qdi_state_e    state_nxt;
  logic [3:0]    tx_r;
  logic [3:0]    tx_nxt;
  logic          cnt_inc;

  // ---- Txe synchronizer: the FSM only ever sees txe_s ----
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (bus.Txe),
    .q   (txe_s)
  );

  // ---- FIFO write side ----
  // in_ready_r is exactly !full, so a push is never accepted at full even if
  // the FSM pops in the same cycle.
  assign push = bus.in_valid & in_ready_r;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // ---- Handshake FSM: state register ----
  always_ff @(posedge CLK) begin
    if (RESET) state <= NEUTRAL;
    else       state <= state_nxt;
  end

  // ---- Handshake FSM: next state ----
  // NEUTRAL waits for the consumer to re-enable (txe_s high) before the next
  // token, which enforces return-to-zero between tokens.
  always_comb begin
    state_nxt = state;
    case (state)
      NEUTRAL: if (txe_s && (count != '0)) state_nxt = VALID;
      VALID:   if (!txe_s)                 state_nxt = NEUTRAL;
      default:                             state_nxt = NEUTRAL;
    endcase
  end

  // ---- Handshake FSM: outputs ----
  // Tx is only ever loaded from NEUTRAL, so one one-hot value can never be
  // replaced directly by another.
  always_comb begin
    tx_nxt  = tx_r;
    pop     = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      NEUTRAL: begin
        if (txe_s && (count != '0)) begin
          tx_nxt = enc_1of4(mem[rd_ptr]);
          pop    = 1'b1;
        end else begin
          tx_nxt = QDI_NEUTRAL;
        end
      end
      VALID: begin
        if (!txe_s) begin
          tx_nxt  = QDI_NEUTRAL;
          cnt_inc = 1'b1;
        end
      end
      default: tx_nxt = QDI_NEUTRAL;
    endcase
  end

  // ---- Registered outputs, pointers and occupancy ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_r       <= QDI_NEUTRAL;
      sent_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_r <= 1'b0;
    end else begin
      tx_r  <= tx_nxt;
      count <= count_nxt;
      // Registered from next occupancy so in_ready tracks !full with no lag.
      in_ready_r <= (count_nxt != OW'(DEPTH));
      if (cnt_inc) sent_count <= sent_count + 1'b1;
      if (push)    wr_ptr     <= wr_ptr + 1'b1;
      if (pop)     rd_ptr     <= rd_ptr + 1'b1;
    end
  end

  assign bus.Tx       = tx_r;
  assign bus.in_ready = in_ready_r;
  assign busy         = (count != '0) | (state == VALID);

endmodule

// File: tb/tb_sync2qdi_1of4.sv
// tb_sync2qdi_1of4: randomized and directed bench for sync2qdi_1of4 with a
// queue-based scoreboard. The stimulus side pushes each accepted word into
// exp_q; an independent monitor pops and compares whenever a new token
// appears on Tx, and checks rail legality and the completed-token count.
`timescale 1ns/1ps
module tb_sync2qdi_1of4;
  import qdi_pkg::*;

  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 16;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             busy;
  logic [CNT_W-1:0] sent_count;

  sync2qdi_1of4_if intf();

  sync2qdi_1of4 #(
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .bus        (intf),
    .busy       (busy),
    .sent_count (sent_count)
  );

  always #5 CLK = ~CLK;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [1:0] exp_q[$];
  int         cons_mode  = 0;   // 0 manual, 1 fixed 3-cycle, 2 random delay
  int         cons_epoch = 0;
  int         exp_sent   = 0;
  logic [3:0] prev_tx    = 4'b0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected rail pattern for word w: rail number w is the only one high.
  function automatic logic [3:0] rail_of(input logic [1:0] w);
    rail_of = 4'(2 ** int'(w));
  endfunction

  // ---- Monitor / scoreboard ----
  always @(posedge CLK) begin
    #1;
    if (RESET) begin
      prev_tx  = 4'b0000;
      exp_sent = 0;
    end else begin
      if (intf.Tx != 4'b0000) begin
        check("tx_onehot", 32'($countones(intf.Tx)), 32'd1);
        check("pkg_is_valid", 32'(is_valid_1of4(intf.Tx)), 32'd1);
      end
      if (prev_tx != 4'b0000 && intf.Tx != 4'b0000)
        check("tx_no_direct_change", intf.Tx, prev_tx);
      if (prev_tx == 4'b0000 && intf.Tx != 4'b0000) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL tx_unexpected: got %0h, expected no token", intf.Tx);
        end else begin
          check("tx_order", intf.Tx, rail_of(exp_q.pop_front()));
        end
      end
      if (prev_tx != 4'b0000 && intf.Tx == 4'b0000) begin
        exp_sent++;
        check("sent_count_track", sent_count, exp_sent);
      end
      prev_tx = intf.Tx;
    end
  end

  // ---- Consumer model ----
  initial begin
    forever begin
      @(negedge CLK);
      if (cons_mode != 0 && !RESET) begin
        int ep;
        int d;
        ep = cons_epoch;
        d  = (cons_mode == 1) ? 3 : int'($urandom_range(1, 6));
        if (intf.Txe && intf.Tx != 4'b0000) begin
          repeat (d - 1) @(negedge CLK);
          if (ep == cons_epoch) intf.Txe = 1'b0;
        end else if (!intf.Txe && intf.Tx == 4'b0000) begin
          repeat (d - 1) @(negedge CLK);
          if (ep == cons_epoch) intf.Txe = 1'b1;
        end
      end
    end
  end

  // ---- Stimulus helpers ----
  task automatic do_reset(input logic txe_v);
    @(negedge CLK);
    cons_epoch++;
    cons_mode     = 0;
    RESET         = 1'b1;
    intf.in_valid = 1'b0;
    intf.Txe      = txe_v;
    exp_q.delete();
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
  endtask

  // One push attempt: in_ready is sampled at the negedge before the edge.
  task automatic push(input logic [1:0] v, output bit acc);
    @(negedge CLK);
    acc           = intf.in_ready;
    intf.in_valid = 1'b1;
    intf.in_data  = v;
    if (acc) exp_q.push_back(v);
    @(posedge CLK);
  endtask

  task automatic idle();
    @(negedge CLK);
    intf.in_valid = 1'b0;
  endtask

  task automatic push_word(input logic [1:0] v);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      push(v, acc);
      tries++;
    end
    if (!acc) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_sent(input string name, input int target, input int budget);
    int i;
    i = 0;
    while (sent_count != CNT_W'(target) && i < budget) begin
      @(posedge CLK);
      #1;
      i++;
    end
    check(name, sent_count, target);
  endtask

  task automatic wait_tx(input string name, input bit want_valid, input int budget);
    int i;
    i = 0;
    while (((intf.Tx != 4'b0000) != want_valid) && i < budget) begin
      @(posedge CLK);
      #1;
      i++;
    end
    check(name, 32'(intf.Tx != 4'b0000), 32'(want_valid));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---- Scenarios ----
  initial begin
    bit         acc;
    logic [1:0] w [6];
    int         k;

    intf.in_valid = 1'b0;
    intf.in_data  = 2'b00;
    intf.Txe      = 1'b1;

    // Reset held 3 cycles with Txe high
    repeat (3) begin
      @(posedge CLK);
      #1;
      check("rst_tx", intf.Tx, 4'b0000);
      check("rst_in_ready", intf.in_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_sent", sent_count, 0);
    end
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_release_in_ready", intf.in_ready, 1'b1);
    check("rst_release_tx", intf.Tx, 4'b0000);

    // Single token, push-to-rail latency and Txe response latency
    repeat (4) @(posedge CLK);
    push(2'b10, acc);
    #1;
    check("single_accept", acc, 1'b1);
    check("single_pre", intf.Tx, 4'b0000);
    idle();
    @(posedge CLK);
    #1;
    check("single_latency", intf.Tx, 4'b0100);
    check("single_busy", busy, 1'b1);
    @(negedge CLK);
    intf.Txe = 1'b0;
    repeat (SYNC_STAGES) @(posedge CLK);
    #1;
    check("single_hold", intf.Tx, 4'b0100);
    @(posedge CLK);
    #1;
    check("single_release", intf.Tx, 4'b0000);
    check("single_sent", sent_count, 1);
    check("single_idle", busy, 1'b0);
    @(negedge CLK);
    intf.Txe = 1'b1;
    repeat (4) @(posedge CLK);

    // Back-pressure: Txe held high, no acknowledge
    do_reset(1'b1);
    repeat (4) @(posedge CLK);
    for (int i = 0; i < 6; i++) w[i] = 2'($urandom_range(0, 3));
    for (int i = 0; i < 5; i++) begin
      push(w[i], acc);
      check("bp_accept", acc, 1'b1);
    end
    push(w[5], acc);
    check("bp_refused", acc, 1'b0);
    idle();
    #1;
    check("bp_full_in_ready", intf.in_ready, 1'b0);
    check("bp_head_on_tx", intf.Tx, rail_of(w[0]));
    check("bp_busy", busy, 1'b1);
    cons_mode = 1;
    wait_sent("bp_sent", 5, 400);
    check("bp_drained", exp_q.size(), 0);
    repeat (8) @(posedge CLK);

    // 40-token sequence with random-delay consumer
    do_reset(1'b1);
    cons_mode = 2;
    for (int i = 0; i < 40; i++) begin
      push_word(2'(i % 4));
      k = int'($urandom_range(0, 2));
      if (k != 0) begin
        idle();
        repeat (k - 1) @(negedge CLK);
      end
    end
    idle();
    wait_sent("seq_sent", 40, 3000);
    check("seq_drained", exp_q.size(), 0);
    repeat (8) @(posedge CLK);

    // Simultaneous push and pop at occupancy 2, then pop at full
    do_reset(1'b0);
    repeat (3) @(posedge CLK);
    for (int i = 0; i < 5; i++) w[i] = 2'($urandom_range(0, 3));
    push(w[0], acc);
    check("sim_accept0", acc, 1'b1);
    push(w[1], acc);
    check("sim_accept1", acc, 1'b1);
    @(negedge CLK);
    intf.in_valid = 1'b0;
    intf.Txe      = 1'b1;
    repeat (SYNC_STAGES) @(posedge CLK);
    push(w[2], acc);            // lands on the pop edge
    #1;
    check("sim_accept2", acc, 1'b1);
    check("sim_pop_tx", intf.Tx, rail_of(w[0]));
    check("sim_in_ready", intf.in_ready, 1'b1);
    push(w[3], acc);
    check("sim_accept3", acc, 1'b1);
    push(w[4], acc);
    check("sim_accept4", acc, 1'b1);
    idle();
    #1;
    check("sim_full", intf.in_ready, 1'b0);
    @(negedge CLK);
    intf.Txe = 1'b0;
    wait_tx("full_neutral", 1'b0, 10);
    @(negedge CLK);
    intf.Txe = 1'b1;
    k = 0;
    while (k < 10) begin
      @(posedge CLK);
      #1;
      k++;
      if (intf.Tx == 4'b0000) begin
        check("full_hold", intf.in_ready, 1'b0);
      end else begin
        check("full_release", intf.in_ready, 1'b1);
        k = 100;
      end
    end
    if (k != 100) check("full_pop_timeout", 32'd0, 32'd1);
    cons_mode = 1;
    wait_sent("sim_sent", 5, 400);
    check("sim_drained", exp_q.size(), 0);
    repeat (8) @(posedge CLK);

    // Reset while a token is on the rails
    do_reset(1'b1);
    repeat (4) @(posedge CLK);
    push(2'b11, acc);
    idle();
    wait_tx("rv_valid", 1'b1, 10);
    check("rv_rail", intf.Tx, 4'b1000);
    @(negedge CLK);
    RESET = 1'b1;
    exp_q.delete();
    @(posedge CLK);
    #1;
    check("rv_tx", intf.Tx, 4'b0000);
    check("rv_sent", sent_count, 0);
    check("rv_busy", busy, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (4) @(posedge CLK);
    w[0] = 2'($urandom_range(0, 3));
    push_word(w[0]);
    idle();
    cons_mode = 1;
    wait_sent("rv_after_sent", 1, 100);
    check("rv_drained", exp_q.size(), 0);
    repeat (4) @(posedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sync2qdi_1of4.md
# sync2qdi_1of4

Clocked-to-QDI bridge that buffers 2-bit synchronous words and issues each one as a 1-of-4 token on a four-phase return-to-zero channel. It sits directly upstream of any QDI 1-of-4 consumer, such as the split/merge stages. It replaces the behavioural transmitter with synthesizable logic so that a clocked host can source tokens. A small FIFO decouples the host from the channel, and a synchronizer brings the asynchronous enable into the clock domain.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2: flops in the Txe synchronizer; at least 2.
- CNT_W, 16: width of the sent-token counter.

- CLK  in  1  single clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- in_data  in  2  word to send.
- in_valid  in  1  host has a word.
- in_ready  out  1  FIFO can accept; registered, equals !full.
- Tx  out  4  1-of-4 data rails; registered; 0000 = neutral.
- Txe  in  1  enable/acknowledge from the consumer; asynchronous; high = ready for data, low = data taken.
- busy  out  1  FIFO non-empty or Tx not neutral.
- sent_count  out  CNT_W  tokens completed (Txe_s fell while in VALID).

## Operation
- Push: in_valid & in_ready at an edge writes in_data at the tail.
- Encoding: the word v drives Tx = 4'b0001 << v. Exactly one rail is high in VALID; all rails are low in NEUTRAL.
- Txe_s is the output of the last synchronizer flop. The FSM sees only Txe_s.
- FSM states:
  - NEUTRAL (reset state): Tx = 0000. If Txe_s = 1 and the FIFO is non-empty, load the head onto Tx, pop, and go to VALID.
  - VALID: Tx holds the one-hot value. If Txe_s = 0, drive Tx = 0000, increment sent_count, and go to NEUTRAL.
- Return to zero: after NEUTRAL is entered, the next token requires Txe_s = 1 again. No token is issued until the consumer re-enables.
- Simultaneous push and pop: allowed when not full; the occupancy count is unchanged. At full, in_ready = 0, so no push is possible even if a pop occurs in the same cycle. in_ready rises one cycle after the pop.
- Occupancy counter width is $clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.
- sent_count wraps from 2^CNT_W−1 to 0.
- busy = (count != 0) | (state == VALID).

## Timing
- Reset values: Tx = 0000, in_ready = 1 on the first edge after RESET falls and 0 while RESET is high, busy = 0, sent_count = 0. Synchronizer flops reset to 0, FIFO is empty, state is NEUTRAL.
- Reset mid-handshake: Tx goes neutral at the next edge regardless of Txe. The consumer must share RESET; a token that is cut off this way is not counted.
- Push-to-rail latency with an empty FIFO and Txe_s = 1: word written at edge N, Tx one-hot after edge N+1.
- Txe edge to Tx response: SYNC_STAGES edges to reach Txe_s, plus 1 edge for the FSM.
- Tx must never change from one one-hot value directly to another; it always passes through 0000 for at least one cycle.
- Tx rails change only on CLK edges, with no combinational path from Txe to Tx.

## Structure
- Shared package qdi_pkg contains:
  - the state enum {NEUTRAL, VALID}
  - constant QDI_NEUTRAL = 4'b0000
  - function enc_1of4(logic [1:0]) returning the one-hot value
  - function is_valid_1of4(logic [3:0]), which checks for exactly one rail high
- Sub-module sync_ff #(STAGES) is a reset-to-0 synchronizer chain, reused for the receive-side bridge.
- The FIFO stays inline.

## Test plan
- Reset: hold RESET high for 3 cycles with Txe = 1 → Tx = 0000, in_ready = 0, then 1 on the first edge after RESET falls, sent_count = 0, busy = 0.
- Single token: push 2'b10 with an ideal consumer model (Txe drops 3 cycles after Tx becomes valid and rises 3 cycles after Tx goes neutral) → Tx = 0100 exactly one cycle after the push edge. Then Tx = 0000 SYNC_STAGES+1 edges after Txe falls, and sent_count = 1.
- Back-pressure: hold Txe = 1 without acknowledging and push 5 words with DEPTH = 4 → the first word is on Tx and 4 are buffered. in_ready = 0 and the 6th push is refused. Then acknowledge 5 times → rails in push order, with 0000 between tokens, sent_count = 5.
- Sequence 00,01,10,11 repeated 10 times (40 tokens) with a random-delay consumer → the checker sees Tx ∈ {0001,0010,0100,1000} in order, is_valid_1of4 holds whenever Tx ≠ 0, and sent_count = 40.
- Simultaneous push and pop at occupancy 2 → occupancy stays 2 and in_ready stays 1. At full, a pop gives in_ready = 1 on the next edge.
- Reset while in VALID (Tx = 1000, Txe = 1) → Tx = 0000 on the next edge, FIFO empty, sent_count = 0. After reset, a new push completes normally.
